// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: opcodes, FSM state type and opcode helper shared by the serial ALU.
package alu_serial_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  // SLT shares the subtract carry chain even though op[1:0] reads as XOR
  function automatic logic is_arith(input logic [2:0] op);
    return (op[1:0] == 2'b10) || (op == OP_SLT);
  endfunction
endpackage

// File: rtl/alu_serial_digit.sv
// alu_digit: combinational DIGIT-bit ALU slice, time-multiplexed across the digits of an operand.
module alu_digit
  import alu_serial_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] r,
  output logic             cout,
  output logic             cin_msb
);
  logic [DIGIT-1:0] bb, sum;
  logic             c;
  always_comb begin
    bb      = op[2] ? ~b : b;
    {c, sum} = {1'b0, a} + {1'b0, bb} + {{DIGIT{1'b0}}, cin};
    cin_msb = sum[DIGIT-1] ^ a[DIGIT-1] ^ bb[DIGIT-1];
    cout    = is_arith(op) & c;
    r       = op[1:0] == 2'b00 ? (a & bb) :
              op[1:0] == 2'b01 ? (a | bb) :
              is_arith(op)     ? sum      : (a ^ bb);
  end
endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU with start/done handshake and SLT.
// Status flags are built only when ALU_SERIAL_FLAGS_EN is defined; otherwise they read 0.
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
  logic             cy_q, cy_d, cmsb_q, cmsb_d, done_q, done_d;
  logic [DIGIT-1:0] r;
  logic             cout, cin_msb, ovf, slt_bit, last;

  // operand registers shift right each RUN edge so the slice always sees digit 0
  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a       (a_q[DIGIT-1:0]),
    .b       (b_q[DIGIT-1:0]),
    .cin     (cy_q),
    .op      (op_q),
    .r       (r),
    .cout    (cout),
    .cin_msb (cin_msb)
  );

  assign last    = cnt_q == CW'(N - 1);
  assign ovf     = cmsb_q ^ cy_q;
  assign slt_bit = sh_q[WIDTH-1] ^ ovf;
  assign ready   = state_q == IDLE;
  assign done    = done_q;
  assign result  = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    cy_d     = cy_q;
    cmsb_d   = cmsb_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        op_d    = op;
        a_d     = a;
        b_d     = b;
        cnt_d   = '0;
        cy_d    = op[2];
      end
      RUN: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        sh_d   = (sh_q >> DIGIT) | (WIDTH'(r) << (WIDTH - DIGIT));
        cy_d   = cout;
        cnt_d  = cnt_q + 1'b1;
        cmsb_d = last ? cin_msb : cmsb_q;
        state_d = last ? FIN : RUN;
      end
      FIN: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        result_d = op_q == OP_SLT ? WIDTH'(slt_bit) : sh_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      cy_q     <= 1'b0;
      cmsb_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      cy_q     <= cy_d;
      cmsb_q   <= cmsb_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, addsub;
  assign addsub = op_q[1:0] == 2'b10;
  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (state_q == FIN) begin
      zero_d  = result_d == '0;
      carry_d = addsub & cy_q;
      ovf_d   = addsub & ovf;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
`else
  assign zero     = 1'b0;
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed test of alu_serial (WIDTH=32, DIGIT=4); flag expectations follow ALU_SERIAL_FLAGS_EN.
module tb_alu_serial;
  import alu_serial_pkg::*;
`ifdef ALU_SERIAL_FLAGS_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0, result;
  logic        ready, done, zero, carry, overflow;
  int          errors = 0, checks = 0, lat = 0;
  logic        seen_done;

  alu_serial #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result),
    .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 30);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
  endtask

  task automatic res(input string tag, input logic [31:0] r, input logic z, input logic c, input logic v);
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_res"}, result, r);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, z & FE});
    chk({tag, "_carry"}, {31'b0, carry}, {31'b0, c & FE});
    chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, v & FE});
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'b0, zero, carry, overflow}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    run(OP_ADD, 32'h7FFFFFFF, 32'h00000001, lat);
    res("add_ovf", 32'h80000000, 1'b0, 1'b0, 1'b1);
    chk("add_ready", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    chk("done_pulse", {31'b0, done}, 32'd0);

    run(OP_SUB, 32'd5, 32'd5, lat);
    res("sub_eq", 32'd0, 1'b1, 1'b1, 1'b0);
    run(OP_SUB, 32'd0, 32'd1, lat);
    res("sub_neg", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run(OP_SLT, 32'hFFFFFFFF, 32'd1, lat);
    res("slt_m1", 32'd1, 1'b0, 1'b0, 1'b0);
    run(OP_SLT, 32'h80000000, 32'h7FFFFFFF, lat);
    res("slt_ovf", 32'd1, 1'b0, 1'b0, 1'b0);
    run(OP_SLT, 32'd3, 32'd3, lat);
    res("slt_eq", 32'd0, 1'b1, 1'b0, 1'b0);

    run(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    res("and", 32'hF000F000, 1'b0, 1'b0, 1'b0);
    run(OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    res("or", 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    run(OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    res("xor", 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    run(OP_ANDN, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    res("andn", 32'h00F000F0, 1'b0, 1'b0, 1'b0);

    // start held high: inputs change mid-RUN, second op taken in the done cycle
    @(negedge clk);
    op = OP_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ready_low", {31'b0, ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    op = OP_SUB; a = 32'd100; b = 32'd30;
    wait_done(lat);
    chk("b2b_first_lat", 32'(lat), 32'd6);
    chk("b2b_first_res", result, 32'd3);
    chk("b2b_done_ready", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_done", {31'b0, done}, 32'd0);
    chk("b2b_accept_ready", {31'b0, ready}, 32'd0);
    wait_done(lat);
    chk("b2b_period", 32'(lat + 1), 32'd10);
    chk("b2b_second_res", result, 32'd70);
    @(posedge clk); #1;
    chk("b2b_idle_done", {31'b0, done}, 32'd0);

    // asynchronous abort mid-RUN
    @(negedge clk);
    op = OP_ADD; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {29'b0, zero, carry, overflow}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen_done = seen_done | done;
    end
    chk("abort_no_done", {31'b0, seen_done}, 32'd0);
    run(OP_ADD, 32'h12345678, 32'h11111111, lat);
    res("post_abort", 32'h23456789, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
